// File: rtl/aes32_sha256_fu.sv
// ---------------------------------------------------------------------------
// aes32_sha256_fu
//
// Execute-stage functional unit for the scalar-crypto instructions
// aes32esi / aes32esmi / aes32dsi / aes32dsmi and
// sha256sig0 / sig1 / sum0 / sum1.
//
// Two-stage pipeline with a valid/ready issue port and a valid/ready
// writeback port:
//   S1 : byte select + forward/inverse S-box lookup, or the full SHA-256
//        rotate/xor function (SHA results are final after S1).
//   S2 : forward/inverse MixColumn column, rotate into byte lane bs,
//        xor with rs1. S2 registers drive the writeback outputs directly.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 kill every in-flight op (incl. one handshaking now)
//   valid_i / ready_o       issue handshake
//   op_i, bs_i              op code (0..7 legal, 8..15 illegal), byte select
//   rs1_i, rs2_i            operands
//   trans_id_i              scoreboard id, echoed on trans_id_o
//   wb_valid_o / wb_ready_i writeback handshake
//   result_o, trans_id_o    result and its id
//   err_o                   illegal op; result_o is 0 in that case
// ---------------------------------------------------------------------------
module aes32_sha256_fu #(
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [3:0]               op_i,
    input  logic [1:0]               bs_i,
    input  logic [XLEN-1:0]          rs1_i,
    input  logic [XLEN-1:0]          rs2_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     err_o
);

    if (XLEN != 32) begin : g_xlen_check
        $error("aes32_sha256_fu supports XLEN == 32 only");
    end

    // ------------------------------------------------------------------
    // GF(2^8) helpers (polynomial x^8 + x^4 + x^3 + x + 1)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox_calc(input logic [7:0] y);
        logic [7:0] a;
        a = rol8(y, 1) ^ rol8(y, 3) ^ rol8(y, 6) ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // ------------------------------------------------------------------
    // S-box ROMs: every entry is an elaboration-time constant, so each
    // table reduces to a 256x8 lookup rather than field arithmetic.
    // ------------------------------------------------------------------
    logic [7:0] w_sbox_rom     [256];
    logic [7:0] w_inv_sbox_rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        assign w_sbox_rom[gi]     = sbox_calc(8'(gi));
        assign w_inv_sbox_rom[gi] = inv_sbox_calc(8'(gi));
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                     r_s1_valid;
    logic [3:0]               r_s1_op;
    logic [1:0]               r_s1_bs;
    logic [31:0]              r_s1_rs1;
    logic [31:0]              r_s1_data;   // {24'b0, so} for AES, final value for SHA
    logic [TRANS_ID_BITS-1:0] r_s1_id;

    logic                     r_s2_valid;
    logic [XLEN-1:0]          r_s2_result;
    logic [TRANS_ID_BITS-1:0] r_s2_id;
    logic                     r_s2_err;

    // S2 can take a new op when empty or when its current one retires;
    // S1 can take one when empty or when it can move into S2.
    logic w_s2_free;
    assign w_s2_free = !r_s2_valid || wb_ready_i;
    assign ready_o   = !r_s1_valid || w_s2_free;

    // ------------------------------------------------------------------
    // S1 combinational: byte select, S-box, SHA functions
    // ------------------------------------------------------------------
    logic [7:0]  w_si;
    logic [31:0] w_sha;
    logic [31:0] w_s1_data;

    assign w_si = rs2_i[{bs_i, 3'b000} +: 8];

    always_comb begin
        w_sha = 32'h0;
        case (op_i[1:0])
            2'd0: w_sha = ror32(rs2_i, 7)  ^ ror32(rs2_i, 18) ^ (rs2_i >> 3);
            2'd1: w_sha = ror32(rs2_i, 17) ^ ror32(rs2_i, 19) ^ (rs2_i >> 10);
            2'd2: w_sha = ror32(rs2_i, 2)  ^ ror32(rs2_i, 13) ^ ror32(rs2_i, 22);
            default: w_sha = ror32(rs2_i, 6) ^ ror32(rs2_i, 11) ^ ror32(rs2_i, 25);
        endcase
    end

    always_comb begin
        w_s1_data = 32'h0;
        if (op_i[3]) begin
            w_s1_data = 32'h0;
        end else if (op_i[2]) begin
            w_s1_data = w_sha;
        end else if (op_i[1]) begin
            w_s1_data = {24'h0, w_inv_sbox_rom[w_si]};
        end else begin
            w_s1_data = {24'h0, w_sbox_rom[w_si]};
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: MixColumn column, lane rotate, xor with rs1
    // ------------------------------------------------------------------
    logic [7:0]  w_so;
    logic [7:0]  w_x2;
    logic [7:0]  w_x4;
    logic [7:0]  w_x8;
    logic [31:0] w_mixed;
    logic [31:0] w_rot;
    logic [XLEN-1:0] w_s2_result;
    logic        w_s2_err;

    assign w_so = r_s1_data[7:0];
    assign w_x2 = xtime(w_so);
    assign w_x4 = xtime(w_x2);
    assign w_x8 = xtime(w_x4);

    always_comb begin
        w_mixed = {24'h0, w_so};
        case (r_s1_op[1:0])
            // ESMI column: {3,1,1,2} * so
            2'd1: w_mixed = {w_x2 ^ w_so, w_so, w_so, w_x2};
            // DSMI column: {0b,0d,09,0e} * so
            2'd3: w_mixed = {w_x8 ^ w_x2 ^ w_so,
                             w_x8 ^ w_x4 ^ w_so,
                             w_x8 ^ w_so,
                             w_x8 ^ w_x4 ^ w_x2};
            default: w_mixed = {24'h0, w_so};
        endcase
    end

    always_comb begin
        w_rot = w_mixed;
        case (r_s1_bs)
            2'd1:    w_rot = {w_mixed[23:0], w_mixed[31:24]};
            2'd2:    w_rot = {w_mixed[15:0], w_mixed[31:16]};
            2'd3:    w_rot = {w_mixed[7:0],  w_mixed[31:8]};
            default: w_rot = w_mixed;
        endcase
    end

    always_comb begin
        w_s2_err    = r_s1_op[3];
        w_s2_result = '0;
        if (r_s1_op[3]) begin
            w_s2_result = '0;
        end else if (r_s1_op[2]) begin
            w_s2_result = r_s1_data;
        end else begin
            w_s2_result = r_s1_rs1 ^ w_rot;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= 4'h0;
            r_s1_bs     <= 2'd0;
            r_s1_rs1    <= 32'h0;
            r_s1_data   <= 32'h0;
            r_s1_id     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_id     <= '0;
            r_s2_err    <= 1'b0;
        end else begin
            if (flush_i) begin
                // Kills both stages and whatever handshakes this cycle.
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_s2_free) r_s2_valid <= r_s1_valid;
                if (ready_o)   r_s1_valid <= valid_i;
            end

            // Payload only moves with a real op, so a stalled S2 keeps its
            // result/id/err stable. Loading under flush is harmless since
            // the valid bits are cleared in the same edge.
            if (w_s2_free && r_s1_valid) begin
                r_s2_result <= w_s2_result;
                r_s2_id     <= r_s1_id;
                r_s2_err    <= w_s2_err;
            end

            if (ready_o && valid_i) begin
                r_s1_op   <= op_i;
                r_s1_bs   <= bs_i;
                r_s1_rs1  <= rs1_i;
                r_s1_data <= w_s1_data;
                r_s1_id   <= trans_id_i;
            end
        end
    end

    assign wb_valid_o = r_s2_valid;
    assign result_o   = r_s2_result;
    assign trans_id_o = r_s2_id;
    assign err_o      = r_s2_err;

endmodule

// File: tb/tb_aes32_sha256_fu.sv
// ---------------------------------------------------------------------------
// tb_aes32_sha256_fu
//
// Scoreboard bench for aes32_sha256_fu. A capture process pushes the
// expected response of every accepted op into a queue; a monitor process
// pops and compares on every retire and also checks ready_o and the
// stall-hold behaviour of the writeback outputs. The reference S-boxes are
// built from brute-force field inversion and the bitwise affine formula.
// ---------------------------------------------------------------------------
module tb_aes32_sha256_fu;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  op_i = 4'h0;
    logic [1:0]  bs_i = 2'd0;
    logic [31:0] rs1_i = 32'h0;
    logic [31:0] rs2_i = 32'h0;
    logic [2:0]  trans_id_i = 3'd0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [31:0] result_o;
    logic [2:0]  trans_id_o;
    logic        err_o;

    aes32_sha256_fu #(.TRANS_ID_BITS(3), .XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .bs_i       (bs_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .trans_id_i (trans_id_i),
        .wb_valid_o (wb_valid_o),
        .wb_ready_i (wb_ready_i),
        .result_o   (result_o),
        .trans_id_o (trans_id_o),
        .err_o      (err_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  id;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [7:0]  sbox_t [256];
    logic [7:0]  inv_t  [256];
    logic        kat_valid = 1'b0;
    logic [31:0] kat_res = 32'h0;
    logic        kat_err = 1'b0;
    logic        bp_run = 1'b0;
    logic        saw_stall = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int aa = int'(a);
        int bb = int'(b);
        while (bb != 0) begin
            if ((bb & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
            bb = bb >> 1;
        end
        return p[7:0];
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    task automatic build_tables();
        logic [7:0] c;
        logic [7:0] b;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (ref_gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_t[sbox_t[x]] = 8'(x);
    endtask

    function automatic exp_t ref_model(input logic [3:0] op, input logic [1:0] bs,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [2:0] id);
        exp_t        e;
        logic [7:0]  si;
        logic [7:0]  so;
        logic [31:0] m;
        logic [63:0] dbl;
        int          sh;
        e.id = id;
        e.err = 1'b0;
        e.res = 32'h0;
        if (op >= 4'd8) begin
            e.err = 1'b1;
            return e;
        end
        case (op)
            4'd4: e.res = ror(rs2, 7)  ^ ror(rs2, 18) ^ (rs2 >> 3);
            4'd5: e.res = ror(rs2, 17) ^ ror(rs2, 19) ^ (rs2 >> 10);
            4'd6: e.res = ror(rs2, 2)  ^ ror(rs2, 13) ^ ror(rs2, 22);
            4'd7: e.res = ror(rs2, 6)  ^ ror(rs2, 11) ^ ror(rs2, 25);
            default: begin
                sh = 8 * int'(bs);
                si = 8'(rs2 >> sh);
                so = (op < 4'd2) ? sbox_t[si] : inv_t[si];
                case (op)
                    4'd1:    m = {ref_gmul(so, 8'h03), so, so, ref_gmul(so, 8'h02)};
                    4'd3:    m = {ref_gmul(so, 8'h0B), ref_gmul(so, 8'h0D),
                                  ref_gmul(so, 8'h09), ref_gmul(so, 8'h0E)};
                    default: m = {24'h0, so};
                endcase
                dbl = {m, m};
                e.res = rs1 ^ 32'(dbl >> (32 - sh));
            end
        endcase
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Capture: record the expected response of each op the DUT accepts.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_i || flush_i) begin
            exp_q.delete();
        end else if (valid_i && ready_o) begin
            e = ref_model(op_i, bs_i, rs1_i, rs2_i, trans_id_i);
            if (kat_valid) begin
                e.res = kat_res;
                e.err = kat_err;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: ready_o, hold-under-stall, and in-order retire checks.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_res = 32'h0;
    logic [2:0]  prev_id = 3'd0;
    logic        prev_err = 1'b0;

    initial forever begin
        exp_t e;
        logic exp_ready;
        @(negedge clk);
        if (rst_i || flush_i) begin
            prev_hold = 1'b0;
        end else begin
            exp_ready = (exp_q.size() < 2) || wb_ready_i;
            n_vec++;
            if (ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL ready_o: got %b, expected %b (in flight %0d, wb_ready %b)",
                         ready_o, exp_ready, exp_q.size(), wb_ready_i);
            end
            if (prev_hold) begin
                n_vec++;
                if (wb_valid_o !== 1'b1 || result_o !== prev_res || trans_id_o !== prev_id || err_o !== prev_err) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b res=%h id=%0d err=%b, expected v=1 res=%h id=%0d err=%b",
                             wb_valid_o, result_o, trans_id_o, err_o, prev_res, prev_id, prev_err);
                end
            end
            if (wb_valid_o === 1'b1 && wb_ready_i) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire_unexpected: got id=%0d res=%h err=%b, expected no result",
                             trans_id_o, result_o, err_o);
                end else begin
                    e = exp_q.pop_front();
                    if (result_o !== e.res || trans_id_o !== e.id || err_o !== e.err) begin
                        n_fail++;
                        $display("FAIL retire: got id=%0d res=%h err=%b, expected id=%0d res=%h err=%b",
                                 trans_id_o, result_o, err_o, e.id, e.res, e.err);
                    end
                end
            end
            prev_hold = (wb_valid_o === 1'b1) && !wb_ready_i;
            prev_res  = result_o;
            prev_id   = trans_id_o;
            prev_err  = err_o;
        end
    end

    // ---------------- stimulus helpers (call at posedge + 1) ----------------
    task automatic send(input logic [3:0] op, input logic [1:0] bs, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [2:0] id);
        int waited = 0;
        valid_i = 1'b1;
        op_i = op;
        bs_i = bs;
        rs1_i = rs1;
        rs2_i = rs2;
        trans_id_i = id;
        @(negedge clk);
        while (!ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: ready_o got 0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        kat_valid = 1'b0;
    endtask

    task automatic kat(input logic [3:0] op, input logic [1:0] bs, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [2:0] id,
                       input logic [31:0] res, input logic err);
        kat_valid = 1'b1;
        kat_res = res;
        kat_err = err;
        send(op, bs, rs1, rs2, id);
    endtask

    task automatic drain();
        wb_ready_i = 1'b1;
        repeat (60) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && !wb_valid_o) break;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        chk({tag, "_result"},   result_o,        32'd0);
        chk({tag, "_trans_id"}, 32'(trans_id_o), 32'd0);
        chk({tag, "_err"},      32'(err_o),      32'd0);
        chk({tag, "_ready"},    32'(ready_o),    32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  op;
        logic [31:0] rs2;
        build_tables();

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Latency: accepted at edge E -> wb_valid_o after edge E+1.
        kat(4'd0, 2'd0, 32'h0, 32'h0, 3'd5, 32'h0000_0063, 1'b0);
        @(negedge clk);
        chk("latency_n1_wb_valid", 32'(wb_valid_o), 32'd0);
        @(negedge clk);
        chk("latency_n2_wb_valid", 32'(wb_valid_o), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Known answers, issued back to back.
        kat(4'd0, 2'd1, 32'h0,         32'h0,         3'd1, 32'h0000_6300, 1'b0);
        kat(4'd1, 2'd0, 32'h0,         32'h0,         3'd2, 32'hA563_63C6, 1'b0);
        kat(4'd0, 2'd0, 32'hFFFF_FFFF, 32'h0,         3'd3, 32'hFFFF_FF9C, 1'b0);
        kat(4'd2, 2'd3, 32'h0,         32'h0,         3'd4, 32'h5200_0000, 1'b0);
        kat(4'd4, 2'd2, 32'h1234_5678, 32'h0000_0001, 3'd5, 32'h0200_4000, 1'b0);
        kat(4'd6, 2'd0, 32'hDEAD_BEEF, 32'h0000_0001, 3'd6, 32'h4008_0400, 1'b0);
        kat(4'd9, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 32'h0,         1'b1);
        drain();

        // Eight back-to-back ops with writeback stalled for three cycles.
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom, 3'(i));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                wb_ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!ready_o) saw_stall = 1'b1;
                    @(posedge clk);
                end
                #1;
                wb_ready_i = 1'b1;
            end
        join
        chk("stall_ready_drop", 32'(saw_stall), 32'd1);
        drain();

        // Flush with two ops in flight plus a handshake in the flush cycle.
        send(4'd1, 2'd2, $urandom, $urandom, 3'd1);
        send(4'd5, 2'd0, $urandom, $urandom, 3'd2);
        valid_i = 1'b1;
        op_i = 4'd3;
        trans_id_i = 3'd3;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("flush_wb_valid", 32'(wb_valid_o), 32'd0);
        @(negedge clk);
        chk("flush_wb_valid_2", 32'(wb_valid_o), 32'd0);
        @(posedge clk);
        #1;
        send(4'd3, 2'd1, 32'hCAFE_F00D, 32'h0012_3400, 3'd4);
        drain();

        // Reset with a stalled, full pipeline.
        wb_ready_i = 1'b0;
        send(4'd1, 2'd3, $urandom, $urandom, 3'd5);
        send(4'd7, 2'd0, $urandom, $urandom, 3'd6);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        wb_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_stale", 32'(wb_valid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        send(4'd2, 2'd0, $urandom, $urandom, 3'd0);
        drain();

        // Random ops plus exhaustive DSMI, under random writeback backpressure.
        bp_run = 1'b1;
        fork
            begin
                while (bp_run) begin
                    @(posedge clk);
                    #1;
                    wb_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(8, 15));
                    else                           op = 4'($urandom_range(0, 7));
                    send(op, 2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)));
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                for (int b = 0; b < 4; b++) begin
                    for (int v = 0; v < 256; v++) begin
                        rs2 = $urandom;
                        rs2[8 * b +: 8] = 8'(v);
                        send(4'd3, 2'(b), $urandom, rs2, 3'(v));
                    end
                end
                bp_run = 1'b0;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
